// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: machine word type shared by all pipeline stages.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/custom_types_pkg.sv
// custom_types_pkg: fetch/decode pipeline register layout and fetch FSM states.
package custom_types_pkg;
    import cpu_types_pkg::*;
    typedef struct packed {
        word_t imemload;
        word_t NPC;
        logic  valid;
    } fetch_t;
    typedef enum logic [1:0] {RUN, PEND, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: fetch stage signal bundle.
//   FE: memory handshake, hazard controls, redirect/halt in; imemREN, imemaddr, fetch_p out.
//   DE: decode reads fetch_p.
interface fetch_if;
    import cpu_types_pkg::*;
    import custom_types_pkg::*;
    logic   ihit, freeze, flush, redirect, halt, imemREN;
    word_t  imemload, redirect_addr, imemaddr;
    fetch_t fetch_p;
    modport FE (
        input  ihit, imemload, freeze, flush, redirect, redirect_addr, halt,
        output imemREN, imemaddr, fetch_p
    );
    modport DE (input fetch_p);
endinterface

// File: rtl/program_counter.sv
// program_counter: PC and pending-redirect registers with the next-PC mux.
//   CLK/RST: clock, async active-high reset.
//   adv_i: PC+4; jmp_i: PC <= tgt_i; go_i: PC <= pending target; pend_ld_i: latch tgt_i.
//   tgt_i: redirect target (low two bits dropped); pc_o: current PC.
module program_counter
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  adv_i,
    input  logic  jmp_i,
    input  logic  go_i,
    input  logic  pend_ld_i,
    input  word_t tgt_i,
    output word_t pc_o
);
    word_t pc_q, pc_d, pend_q, pend_d, tgt;

    assign tgt  = {tgt_i[31:2], 2'b00};
    assign pc_o = pc_q;

    always_comb begin
        pc_d   = jmp_i ? tgt : go_i ? pend_q : adv_i ? pc_q + 32'd4 : pc_q;
        pend_d = pend_ld_i ? tgt : pend_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q   <= PC_INIT;
            pend_q <= '0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with redirect-while-outstanding handling.
//   CLK/RST: clock, async active-high reset.
//   fif (FE): ihit/imemload from memory, freeze/flush/redirect/halt controls;
//             drives imemREN, imemaddr (= PC) and the fetch_p register toward decode.
module fetch_stage
    import cpu_types_pkg::*;
    import custom_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input logic CLK,
    input logic RST,
    fetch_if.FE fif
);
    fetch_state_t state_q, state_d;
    fetch_t       fp_q, fp_d;
    word_t        pc;
    logic         run, pend, live, adv, jmp, go, pend_ld;

    program_counter #(.PC_INIT(PC_INIT)) u_pc (
        .CLK       (CLK),
        .RST       (RST),
        .adv_i     (adv),
        .jmp_i     (jmp),
        .go_i      (go),
        .pend_ld_i (pend_ld),
        .tgt_i     (fif.redirect_addr),
        .pc_o      (pc)
    );

    always_comb begin
        run     = state_q == RUN;
        pend    = state_q == PEND;
        live    = (run || pend) && !fif.halt;
        // A redirect landing with ihit jumps straight away (in PEND it is the youngest, so it wins).
        jmp     = live && fif.redirect && fif.ihit;
        // Without ihit the memory still owns imemaddr, so the target is parked instead.
        pend_ld = live && fif.redirect && !fif.ihit;
        go      = live && pend && fif.ihit;
        adv     = live && run && !fif.redirect && !fif.flush && !fif.freeze && fif.ihit;
        state_d = !(run || pend) ? state_q :
                  fif.halt       ? HALTED  :
                  pend_ld        ? PEND    :
                  fif.ihit       ? RUN     : state_q;
        // The word returned in PEND belongs to the squashed path and is dropped.
        fp_d    = !(run || pend) ? fp_q :
                  (fif.halt || fif.redirect || fif.flush || (pend && fif.ihit)) ? '0 :
                  adv ? {fif.imemload, pc + 32'd4, 1'b1} : fp_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            fp_q    <= '0;
        end else begin
            state_q <= state_d;
            fp_q    <= fp_d;
        end
    end

    assign fif.imemaddr = pc;
    assign fif.imemREN  = (state_q != HALTED) && !RST;
    assign fif.fetch_p  = fp_q;
endmodule
